// File: rtl/ddr_multi_queue_mgr.sv
// Multi-queue DDR region manager: per-queue circular write allocation, descriptor FIFOs,
// budgeted single-queue drain and space release on read completion.
module ddr_multi_queue_mgr #(
    parameter int unsigned                  C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] P_BASE_ADDR       = '0,
    parameter int unsigned                  P_QUEUE_NUM        = 4,
    parameter logic [31:0]                  P_QUEUE_SPAN       = 32'h0040_0000,
    parameter int unsigned                  P_DESC_DEPTH       = 64,
    parameter int unsigned                  P_INFLIGHT         = 8,
    parameter int unsigned                  P_BEAT_SHIFT       = 3,
    localparam int unsigned                 QW = (P_QUEUE_NUM > 1) ? $clog2(P_QUEUE_NUM) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_alloc_valid,
    input  logic [QW-1:0]                 i_alloc_qid,
    input  logic [15:0]                   i_alloc_len,
    output logic                          o_alloc_ready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_alloc_addr,
    input  logic                          i_wr_cpl_valid,
    output logic                          o_wr_cpl_ready,
    input  logic [QW-1:0]                 i_wr_cpl_qid,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_wr_cpl_addr,
    input  logic [15:0]                   i_wr_cpl_len,
    input  logic [7:0]                    i_wr_cpl_strb,
    input  logic                          i_drain_valid,
    output logic                          o_drain_ready,
    input  logic [QW-1:0]                 i_drain_qid,
    input  logic [31:0]                   i_drain_budget,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_rd_addr,
    output logic [15:0]                   o_rd_len,
    output logic [7:0]                    o_rd_strb,
    input  logic                          i_rd_ddr_cpl,
    output logic                          o_drain_done,
    output logic [31:0]                   o_drain_bytes,
    output logic [32*P_QUEUE_NUM-1:0]     o_queue_size,
    output logic [P_QUEUE_NUM-1:0]        o_queue_full
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = (P_DESC_DEPTH > 1) ? $clog2(P_DESC_DEPTH) : 1;
    localparam int unsigned IW = (P_INFLIGHT > 1) ? $clog2(P_INFLIGHT) : 1;
    localparam logic [DW:0] DEPTH_C = (DW+1)'(P_DESC_DEPTH);
    localparam logic [IW:0] INFL_C  = (IW+1)'(P_INFLIGHT);

    // Byte arithmetic is two bits wider than offsets so span-edge sums never overflow.
    typedef logic [33:0] sz_t;
    localparam sz_t SPAN = {2'b00, P_QUEUE_SPAN};

    typedef enum logic [1:0] {StIdle, StCheck, StIssue, StDone} st_t;

    function automatic logic [AW-1:0] base_of(input logic [QW-1:0] q);
        return P_BASE_ADDR + AW'(q) * AW'(P_QUEUE_SPAN);
    endfunction

    function automatic logic [DW-1:0] nxt_d(input logic [DW-1:0] p);
        return (p == DW'(P_DESC_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IW-1:0] nxt_i(input logic [IW-1:0] p);
        return (p == IW'(P_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [31:0]     wr_off   [P_QUEUE_NUM];
    logic [31:0]     rd_off   [P_QUEUE_NUM];
    logic [31:0]     used     [P_QUEUE_NUM];
    logic [31:0]     qsize    [P_QUEUE_NUM];
    logic [31:0]     used_nxt [P_QUEUE_NUM];
    logic [31:0]     qsize_nxt[P_QUEUE_NUM];
    logic [P_QUEUE_NUM-1:0] full_q, full_nxt;

    logic [AW-1:0]   d_addr [P_QUEUE_NUM][P_DESC_DEPTH];
    logic [15:0]     d_len  [P_QUEUE_NUM][P_DESC_DEPTH];
    logic [7:0]      d_strb [P_QUEUE_NUM][P_DESC_DEPTH];
    logic [DW-1:0]   d_wptr [P_QUEUE_NUM];
    logic [DW-1:0]   d_rptr [P_QUEUE_NUM];
    logic [DW:0]     d_cnt  [P_QUEUE_NUM];

    logic [QW-1:0]   f_qid  [P_INFLIGHT];
    logic [31:0]     f_freed[P_INFLIGHT];
    logic [IW-1:0]   f_wptr, f_rptr;
    logic [IW:0]     f_cnt;

    st_t             state;
    logic [QW-1:0]   dq;
    logic [31:0]     budget, sent;

    logic            aq_ok, wq_ok, dq_ok, alloc_grant, wr_push;
    sz_t             a_s, a_wr, a_used, a_start, a_waste, a_end, w_s;
    logic            head_empty, over_budget, infl_full, desc_pop, rd_acc, rel;
    logic [AW-1:0]   h_addr, r_diff;
    logic [15:0]     h_len;
    logic [7:0]      h_strb;
    sz_t             h_s, r_s, r_off, r_rdoff, r_freed, r_end;
    logic [QW-1:0]   rel_q;
    logic [31:0]     rel_freed;

    always_comb begin
        aq_ok  = 32'(i_alloc_qid) < P_QUEUE_NUM;
        wq_ok  = 32'(i_wr_cpl_qid) < P_QUEUE_NUM;
        dq_ok  = 32'(dq) < P_QUEUE_NUM;
        a_s    = sz_t'(i_alloc_len) << P_BEAT_SHIFT;
        a_wr   = '0;
        a_used = '0;
        if (aq_ok) begin
            a_wr   = sz_t'(wr_off[i_alloc_qid]);
            a_used = sz_t'(used[i_alloc_qid]);
        end
        // A request that would straddle the region end restarts at offset 0, wasting the tail.
        if (a_wr + a_s > SPAN) begin
            a_start = '0;
            a_waste = SPAN - a_wr;
        end else begin
            a_start = a_wr;
            a_waste = '0;
        end
        a_end       = a_start + a_s;
        alloc_grant = i_alloc_valid && !o_alloc_ready && aq_ok && (a_s != '0) &&
                      (a_used + a_waste + a_s <= SPAN);

        o_wr_cpl_ready = !i_rst && wq_ok && (d_cnt[i_wr_cpl_qid] != DEPTH_C);
        wr_push        = i_wr_cpl_valid && o_wr_cpl_ready;
        w_s            = sz_t'(i_wr_cpl_len) << P_BEAT_SHIFT;

        h_addr = '0;
        h_len  = '0;
        h_strb = '0;
        head_empty = 1'b1;
        if (dq_ok) begin
            h_addr     = d_addr[dq][d_rptr[dq]];
            h_len      = d_len[dq][d_rptr[dq]];
            h_strb     = d_strb[dq][d_rptr[dq]];
            head_empty = (d_cnt[dq] == '0);
        end
        h_s         = sz_t'(h_len) << P_BEAT_SHIFT;
        over_budget = sz_t'(sent) + h_s > sz_t'(budget);
        infl_full   = (f_cnt == INFL_C);
        desc_pop    = (state == StCheck) && !head_empty && !over_budget && !infl_full;
        rd_acc      = (state == StIssue) && i_rd_ready;
        o_drain_ready = !i_rst && (state == StIdle);

        r_diff  = o_rd_addr - base_of(dq);
        r_off   = sz_t'(r_diff) & (SPAN - 1'b1);
        r_s     = sz_t'(o_rd_len) << P_BEAT_SHIFT;
        r_rdoff = dq_ok ? sz_t'(rd_off[dq]) : '0;
        // Freed space spans from the last read end, so it absorbs any wrap waste in between.
        r_freed = (r_off >= r_rdoff) ? r_off + r_s - r_rdoff : SPAN - r_rdoff + r_off + r_s;
        r_end   = r_off + r_s;

        rel       = i_rd_ddr_cpl && (f_cnt != '0);
        rel_q     = f_qid[f_rptr];
        rel_freed = f_freed[f_rptr];

        for (int q = 0; q < P_QUEUE_NUM; q++) begin
            used_nxt[q]  = used[q];
            qsize_nxt[q] = qsize[q];
            if (alloc_grant && i_alloc_qid == QW'(q)) used_nxt[q] = used_nxt[q] + 32'(a_waste + a_s);
            if (rel && rel_q == QW'(q))               used_nxt[q] = used_nxt[q] - rel_freed;
            if (wr_push && i_wr_cpl_qid == QW'(q))    qsize_nxt[q] = qsize_nxt[q] + 32'(w_s);
            if (rd_acc && dq == QW'(q))               qsize_nxt[q] = qsize_nxt[q] - 32'(r_s);
            full_nxt[q] = sz_t'(used_nxt[q]) + 34'd2048 > SPAN;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= StIdle;
            dq            <= '0;
            budget        <= '0;
            sent          <= '0;
            o_rd_valid    <= 1'b0;
            o_rd_addr     <= '0;
            o_rd_len      <= '0;
            o_rd_strb     <= '0;
            o_drain_done  <= 1'b0;
            o_drain_bytes <= '0;
        end else begin
            o_drain_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (i_drain_valid) begin
                        dq     <= i_drain_qid;
                        budget <= i_drain_budget;
                        sent   <= '0;
                        state  <= StCheck;
                    end
                end
                StCheck: begin
                    if (head_empty || over_budget) begin
                        state <= StDone;
                    end else if (!infl_full) begin
                        o_rd_valid <= 1'b1;
                        o_rd_addr  <= h_addr;
                        o_rd_len   <= h_len;
                        o_rd_strb  <= h_strb;
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    if (i_rd_ready) begin
                        o_rd_valid <= 1'b0;
                        sent       <= sent + 32'(r_s);
                        state      <= StCheck;
                    end
                end
                StDone: begin
                    o_drain_done  <= 1'b1;
                    o_drain_bytes <= sent;
                    state         <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_alloc_ready <= 1'b0;
            o_alloc_addr  <= '0;
            full_q        <= '0;
            f_wptr        <= '0;
            f_rptr        <= '0;
            f_cnt         <= '0;
            for (int q = 0; q < P_QUEUE_NUM; q++) begin
                wr_off[q] <= '0;
                rd_off[q] <= '0;
                used[q]   <= '0;
                qsize[q]  <= '0;
                d_wptr[q] <= '0;
                d_rptr[q] <= '0;
                d_cnt[q]  <= '0;
            end
        end else begin
            o_alloc_ready <= alloc_grant;
            if (alloc_grant) o_alloc_addr <= base_of(i_alloc_qid) + AW'(a_start);
            full_q <= full_nxt;
            for (int q = 0; q < P_QUEUE_NUM; q++) begin
                used[q]  <= used_nxt[q];
                qsize[q] <= qsize_nxt[q];
                if (alloc_grant && i_alloc_qid == QW'(q))
                    wr_off[q] <= (a_end == SPAN) ? '0 : 32'(a_end);
                if (rd_acc && dq == QW'(q))
                    rd_off[q] <= (r_end == SPAN) ? '0 : 32'(r_end);
                if (wr_push && i_wr_cpl_qid == QW'(q)) d_wptr[q] <= nxt_d(d_wptr[q]);
                if (desc_pop && dq == QW'(q))          d_rptr[q] <= nxt_d(d_rptr[q]);
                if ((wr_push && i_wr_cpl_qid == QW'(q)) && !(desc_pop && dq == QW'(q)))
                    d_cnt[q] <= d_cnt[q] + 1'b1;
                else if (!(wr_push && i_wr_cpl_qid == QW'(q)) && (desc_pop && dq == QW'(q)))
                    d_cnt[q] <= d_cnt[q] - 1'b1;
            end
            if (rd_acc) f_wptr <= nxt_i(f_wptr);
            if (rel)    f_rptr <= nxt_i(f_rptr);
            if (rd_acc && !rel)      f_cnt <= f_cnt + 1'b1;
            else if (!rd_acc && rel) f_cnt <= f_cnt - 1'b1;
        end
    end

    // Storage arrays carry no reset; pointers and counts define validity.
    always_ff @(posedge i_clk) begin
        if (wr_push) begin
            d_addr[i_wr_cpl_qid][d_wptr[i_wr_cpl_qid]] <= i_wr_cpl_addr;
            d_len[i_wr_cpl_qid][d_wptr[i_wr_cpl_qid]]  <= i_wr_cpl_len;
            d_strb[i_wr_cpl_qid][d_wptr[i_wr_cpl_qid]] <= i_wr_cpl_strb;
        end
        if (rd_acc) begin
            f_qid[f_wptr]   <= dq;
            f_freed[f_wptr] <= 32'(r_freed);
        end
    end

    assign o_queue_full = full_q;

    for (genvar g = 0; g < P_QUEUE_NUM; g++) begin : g_qsize
        assign o_queue_size[32*g +: 32] = qsize[g];
    end

endmodule

// File: tb/tb_ddr_multi_queue_mgr.sv
// Directed bench: dut_a uses the default 4 MiB span, dut_b a 4 KiB span for wrap/full cases.
module tb_ddr_multi_queue_mgr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        alloc_valid, wr_valid, drain_valid, rd_ready, rd_ddr_cpl;
    logic [1:0]  alloc_qid, wr_qid, drain_qid;
    logic [15:0] alloc_len, wr_len;
    logic [31:0] wr_addr, drain_budget;
    logic [7:0]  wr_strb;

    logic        a_alloc_ready, a_wr_ready, a_drain_ready, a_rd_valid, a_drain_done;
    logic        b_alloc_ready, b_wr_ready, b_drain_ready, b_rd_valid, b_drain_done;
    logic [31:0] a_alloc_addr, a_rd_addr, a_drain_bytes, b_alloc_addr, b_rd_addr, b_drain_bytes;
    logic [15:0] a_rd_len, b_rd_len;
    logic [7:0]  a_rd_strb, b_rd_strb;
    logic [127:0] a_qsize, b_qsize;
    logic [3:0]  a_qfull, b_qfull;

    logic        sel;
    wire         s_alloc_ready = sel ? b_alloc_ready : a_alloc_ready;
    wire [31:0]  s_alloc_addr  = sel ? b_alloc_addr  : a_alloc_addr;
    wire         s_wr_ready    = sel ? b_wr_ready    : a_wr_ready;
    wire         s_drain_ready = sel ? b_drain_ready : a_drain_ready;
    wire         s_rd_valid    = sel ? b_rd_valid    : a_rd_valid;
    wire [31:0]  s_rd_addr     = sel ? b_rd_addr     : a_rd_addr;
    wire [15:0]  s_rd_len      = sel ? b_rd_len      : a_rd_len;
    wire [7:0]   s_rd_strb     = sel ? b_rd_strb     : a_rd_strb;
    wire         s_drain_done  = sel ? b_drain_done  : a_drain_done;
    wire [31:0]  s_drain_bytes = sel ? b_drain_bytes : a_drain_bytes;
    wire [127:0] s_qsize       = sel ? b_qsize       : a_qsize;
    wire [3:0]   s_qfull       = sel ? b_qfull       : a_qfull;

    int n_cmp = 0;
    int n_err = 0;

    ddr_multi_queue_mgr #(.P_QUEUE_SPAN(32'h0040_0000)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_alloc_valid(alloc_valid), .i_alloc_qid(alloc_qid), .i_alloc_len(alloc_len),
        .o_alloc_ready(a_alloc_ready), .o_alloc_addr(a_alloc_addr),
        .i_wr_cpl_valid(wr_valid), .o_wr_cpl_ready(a_wr_ready), .i_wr_cpl_qid(wr_qid),
        .i_wr_cpl_addr(wr_addr), .i_wr_cpl_len(wr_len), .i_wr_cpl_strb(wr_strb),
        .i_drain_valid(drain_valid), .o_drain_ready(a_drain_ready), .i_drain_qid(drain_qid),
        .i_drain_budget(drain_budget),
        .o_rd_valid(a_rd_valid), .i_rd_ready(rd_ready), .o_rd_addr(a_rd_addr),
        .o_rd_len(a_rd_len), .o_rd_strb(a_rd_strb), .i_rd_ddr_cpl(rd_ddr_cpl),
        .o_drain_done(a_drain_done), .o_drain_bytes(a_drain_bytes),
        .o_queue_size(a_qsize), .o_queue_full(a_qfull)
    );

    ddr_multi_queue_mgr #(.P_QUEUE_SPAN(32'h0000_1000)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_alloc_valid(alloc_valid), .i_alloc_qid(alloc_qid), .i_alloc_len(alloc_len),
        .o_alloc_ready(b_alloc_ready), .o_alloc_addr(b_alloc_addr),
        .i_wr_cpl_valid(wr_valid), .o_wr_cpl_ready(b_wr_ready), .i_wr_cpl_qid(wr_qid),
        .i_wr_cpl_addr(wr_addr), .i_wr_cpl_len(wr_len), .i_wr_cpl_strb(wr_strb),
        .i_drain_valid(drain_valid), .o_drain_ready(b_drain_ready), .i_drain_qid(drain_qid),
        .i_drain_budget(drain_budget),
        .o_rd_valid(b_rd_valid), .i_rd_ready(rd_ready), .o_rd_addr(b_rd_addr),
        .o_rd_len(b_rd_len), .o_rd_strb(b_rd_strb), .i_rd_ddr_cpl(rd_ddr_cpl),
        .o_drain_done(b_drain_done), .o_drain_bytes(b_drain_bytes),
        .o_queue_size(b_qsize), .o_queue_full(b_qfull)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_valid = 0; alloc_qid = 0; alloc_len = 0;
        wr_valid = 0; wr_qid = 0; wr_addr = 0; wr_len = 0; wr_strb = 0;
        drain_valid = 0; drain_qid = 0; drain_budget = 0;
        rd_ready = 0; rd_ddr_cpl = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_inputs();
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_alloc(input logic [1:0] q, input logic [15:0] len, output logic [31:0] addr);
        bit got = 0;
        alloc_valid = 1; alloc_qid = q; alloc_len = len; addr = '1;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (s_alloc_ready) begin
                got  = 1;
                addr = s_alloc_addr;
            end
        end
        alloc_valid = 0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL alloc_timeout q=%0d len=%0d: got ready 0, required 1", q, len);
        end
    endtask

    task automatic do_wr(input logic [1:0] q, input logic [31:0] addr, input logic [15:0] len,
                         input logic [7:0] strb);
        bit done = 0;
        wr_valid = 1; wr_qid = q; wr_addr = addr; wr_len = len; wr_strb = strb;
        for (int k = 0; k < 20; k++) begin
            if (s_wr_ready) begin
                done = 1;
                tick();
                break;
            end
            tick();
        end
        wr_valid = 0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL wr_timeout q=%0d: got ready 0, required 1", q);
        end
    endtask

    task automatic do_drain(input logic [1:0] q, input logic [31:0] bud, output int nrd,
                            output logic [31:0] bytes, output logic [31:0] f_addr,
                            output logic [15:0] f_len, output logic [7:0] f_strb);
        bit done = 0;
        nrd = 0; bytes = '1; f_addr = '1; f_len = '1; f_strb = '1;
        rd_ready = 1; drain_valid = 1; drain_qid = q; drain_budget = bud;
        tick();
        drain_valid = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (s_rd_valid) begin
                if (nrd == 0) begin
                    f_addr = s_rd_addr; f_len = s_rd_len; f_strb = s_rd_strb;
                end
                nrd++;
            end
            if (s_drain_done) begin
                done  = 1;
                bytes = s_drain_bytes;
            end
            if (!done) tick();
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout q=%0d: got done 0, required 1", q);
        end
    endtask

    task automatic rd_cpl(input int n);
        for (int k = 0; k < n; k++) begin
            rd_ddr_cpl = 1;
            tick();
        end
        rd_ddr_cpl = 0;
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1;
        clear_inputs();
        tick();
        tick();
        n_cmp++;
        if ({s_wr_ready, s_drain_ready, s_alloc_ready, s_rd_valid, s_drain_done} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {s_wr_ready, s_drain_ready, s_alloc_ready, s_rd_valid, s_drain_done});
        end
        n_cmp++;
        if ({s_alloc_addr, s_rd_addr, s_drain_bytes, s_qsize, s_qfull} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got alloc_addr %h rd_addr %h bytes %h qsize %h full %b, required 0",
                     s_alloc_addr, s_rd_addr, s_drain_bytes, s_qsize, s_qfull);
        end
        rst = 0;
        tick();
        n_cmp++;
        if (s_drain_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_drain_ready: got %b, required 1", s_drain_ready);
        end
    endtask

    task automatic test_single();
        logic [31:0] addr, bytes, fa;
        logic [15:0] fl;
        logic [7:0]  fs;
        int nrd;
        do_alloc(2, 16'd190, addr);
        n_cmp++;
        if (addr !== 32'h0080_0000) begin
            n_err++; $display("FAIL single_alloc_addr: got %h, required 00800000", addr);
        end
        do_wr(2, addr, 16'd190, 8'h3F);
        n_cmp++;
        if (s_qsize[95:64] !== 32'd1520) begin
            n_err++; $display("FAIL single_qsize_wr: got %0d, required 1520", s_qsize[95:64]);
        end
        do_drain(2, 32'd4000, nrd, bytes, fa, fl, fs);
        n_cmp++;
        if (nrd !== 1 || fa !== 32'h0080_0000 || fl !== 16'd190 || fs !== 8'h3F) begin
            n_err++;
            $display("FAIL single_read: got n=%0d addr=%h len=%0d strb=%h, required n=1 addr=00800000 len=190 strb=3f",
                     nrd, fa, fl, fs);
        end
        n_cmp++;
        if (bytes !== 32'd1520 || s_qsize[95:64] !== 32'd0) begin
            n_err++;
            $display("FAIL single_bytes: got bytes=%0d qsize=%0d, required 1520 and 0",
                     bytes, s_qsize[95:64]);
        end
        rd_cpl(1);
    endtask

    task automatic test_budget();
        logic [31:0] a0, a1, a2, bytes, fa;
        logic [15:0] fl;
        logic [7:0]  fs;
        int nrd;
        do_alloc(0, 16'd125, a0);
        do_alloc(0, 16'd125, a1);
        do_alloc(0, 16'd125, a2);
        n_cmp++;
        if (a0 !== 32'd0 || a1 !== 32'd1000 || a2 !== 32'd2000) begin
            n_err++; $display("FAIL budget_addrs: got %0d %0d %0d, required 0 1000 2000", a0, a1, a2);
        end
        do_wr(0, a0, 16'd125, 8'hFF);
        do_wr(0, a1, 16'd125, 8'hFF);
        do_wr(0, a2, 16'd125, 8'hFF);
        do_drain(0, 32'd2500, nrd, bytes, fa, fl, fs);
        n_cmp++;
        if (nrd !== 2 || bytes !== 32'd2000) begin
            n_err++; $display("FAIL budget_cut: got n=%0d bytes=%0d, required 2 and 2000", nrd, bytes);
        end
        n_cmp++;
        if (s_qsize[31:0] !== 32'd1000) begin
            n_err++; $display("FAIL budget_qsize: got %0d, required 1000", s_qsize[31:0]);
        end
        rd_cpl(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr, bytes;
        int nacc = 0;
        bit seen_done = 0;
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            do_alloc(3, 16'd1, addr);
            do_wr(3, addr, 16'd1, 8'h01);
        end
        n_cmp++;
        if (addr !== 32'h00C0_0040) begin
            n_err++; $display("FAIL b2b_last_addr: got %h, required 00c00040", addr);
        end
        rd_ready = 0; drain_valid = 1; drain_qid = 3; drain_budget = 32'd1000;
        tick();
        drain_valid = 0;
        for (int k = 0; k < 10 && !s_rd_valid; k++) tick();
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (s_rd_valid !== 1'b1 || s_rd_addr !== 32'h00C0_0000) begin
                n_err++;
                $display("FAIL b2b_hold cycle %0d: got valid=%b addr=%h, required 1 and 00c00000",
                         k, s_rd_valid, s_rd_addr);
            end
            tick();
        end
        rd_ready = 1;
        for (int k = 0; k < 40; k++) begin
            if (s_rd_valid) nacc++;
            if (s_drain_done) seen_done = 1;
            tick();
        end
        n_cmp++;
        if (nacc !== 8 || seen_done !== 1'b0 || s_rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_inflight_cap: got reads=%0d done=%b valid=%b, required 8, 0, 0",
                     nacc, seen_done, s_rd_valid);
        end
        rd_cpl(1);
        nacc = 0;
        bytes = '1;
        for (int k = 0; k < 20 && !seen_done; k++) begin
            if (s_rd_valid) nacc++;
            if (s_drain_done) begin
                seen_done = 1;
                bytes = s_drain_bytes;
            end
            if (!seen_done) tick();
        end
        n_cmp++;
        if (nacc !== 1 || seen_done !== 1'b1 || bytes !== 32'd72) begin
            n_err++;
            $display("FAIL b2b_resume: got reads=%0d done=%b bytes=%0d, required 1, 1, 72",
                     nacc, seen_done, bytes);
        end
        rd_cpl(9);
        n_cmp++;
        if (s_qsize[127:96] !== 32'd0 || s_qfull !== 4'b0) begin
            n_err++;
            $display("FAIL b2b_final: got qsize=%0d full=%b, required 0 and 0000",
                     s_qsize[127:96], s_qfull);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] addr;
        bit seen_done = 0;
        do_alloc(0, 16'd10, addr);
        do_wr(0, addr, 16'd10, 8'hFF);
        rd_ready = 0; drain_valid = 1; drain_qid = 0; drain_budget = 32'd1000;
        tick();
        drain_valid = 0;
        for (int k = 0; k < 10 && !s_rd_valid; k++) tick();
        n_cmp++;
        if (s_rd_valid !== 1'b1) begin
            n_err++; $display("FAIL midrst_issue: got valid=%b, required 1", s_rd_valid);
        end
        rst = 1;
        #1;
        n_cmp++;
        if ({s_rd_valid, s_drain_ready, s_wr_ready, s_alloc_ready} !== 4'b0 ||
            s_rd_addr !== 32'd0 || s_alloc_addr !== 32'd0 || s_qsize !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: got valid=%b rd_addr=%h alloc_addr=%h qsize=%h, required 0",
                     s_rd_valid, s_rd_addr, s_alloc_addr, s_qsize);
        end
        tick();
        tick();
        rst = 0;
        rd_ready = 1;
        for (int k = 0; k < 6; k++) begin
            if (s_drain_done) seen_done = 1;
            tick();
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_err++; $display("FAIL midrst_no_done: got done pulse 1, required 0");
        end
        do_alloc(0, 16'd4, addr);
        n_cmp++;
        if (addr !== 32'd0) begin
            n_err++; $display("FAIL midrst_alloc: got %h, required 00000000", addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a0, a1, a2, a3, a4, bytes, fa;
        logic [15:0] fl;
        logic [7:0]  fs;
        int nrd;
        sel = 1;
        reset_dut();
        do_alloc(0, 16'd200, a0);
        do_alloc(0, 16'd200, a1);
        do_wr(0, a0, 16'd200, 8'hFF);
        do_wr(0, a1, 16'd200, 8'hFF);
        do_drain(0, 32'd10000, nrd, bytes, fa, fl, fs);
        n_cmp++;
        if (a0 !== 32'd0 || a1 !== 32'd1600 || nrd !== 2 || bytes !== 32'd3200) begin
            n_err++;
            $display("FAIL wrap_first: got a0=%0d a1=%0d n=%0d bytes=%0d, required 0 1600 2 3200",
                     a0, a1, nrd, bytes);
        end
        rd_cpl(2);
        do_alloc(0, 16'd200, a2);
        n_cmp++;
        if (a2 !== 32'd0 || s_qfull[0] !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_alloc: got addr=%0d full=%b, required 0 and 1", a2, s_qfull[0]);
        end
        do_wr(0, a2, 16'd200, 8'hFF);
        do_drain(0, 32'd10000, nrd, bytes, fa, fl, fs);
        rd_cpl(1);
        n_cmp++;
        if (nrd !== 1 || fa !== 32'd0 || s_qfull[0] !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_release: got n=%0d addr=%0d full=%b, required 1 0 0",
                     nrd, fa, s_qfull[0]);
        end
        // Exact-span fill succeeds only if the waste was released along with the data.
        do_alloc(0, 16'd312, a3);
        do_alloc(0, 16'd200, a4);
        n_cmp++;
        if (a3 !== 32'd1600 || a4 !== 32'd0 || s_qfull[0] !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_exact_fill: got %0d %0d full=%b, required 1600 0 1",
                     a3, a4, s_qfull[0]);
        end
    endtask

    task automatic test_full();
        logic [31:0] a [4];
        logic [31:0] bytes, fa;
        logic [15:0] fl;
        logic [7:0]  fs;
        int nrd;
        sel = 1;
        reset_dut();
        for (int i = 0; i < 4; i++) do_alloc(1, 16'd125, a[i]);
        n_cmp++;
        if (a[0] !== 32'd4096 || a[3] !== 32'd7096 || s_qfull !== 4'b0010) begin
            n_err++;
            $display("FAIL full_fill: got a0=%0d a3=%0d full=%b, required 4096 7096 0010",
                     a[0], a[3], s_qfull);
        end
        for (int i = 0; i < 4; i++) do_wr(1, a[i], 16'd125, 8'hFF);
        do_drain(1, 32'd1000, nrd, bytes, fa, fl, fs);
        n_cmp++;
        if (nrd !== 1 || fa !== 32'd4096 || bytes !== 32'd1000) begin
            n_err++;
            $display("FAIL full_drain: got n=%0d addr=%0d bytes=%0d, required 1 4096 1000",
                     nrd, fa, bytes);
        end
        alloc_valid = 1; alloc_qid = 1; alloc_len = 16'd25;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (s_alloc_ready !== 1'b0) begin
                n_err++; $display("FAIL full_refuse cycle %0d: got ready 1, required 0", k);
            end
        end
        rd_cpl(1);
        tick();
        n_cmp++;
        if (s_alloc_ready !== 1'b1 || s_alloc_addr !== 32'd4096) begin
            n_err++;
            $display("FAIL full_grant_after_release: got ready=%b addr=%0d, required 1 and 4096",
                     s_alloc_ready, s_alloc_addr);
        end
        alloc_valid = 0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0;
        rst = 1;
        clear_inputs();
        test_reset();
        test_single();
        test_budget();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_multi_queue_mgr.md
Name: ddr_multi_queue_mgr

Overview:
- Parametrised successor of the single-queue DDR local queue.
- Manages P_QUEUE_NUM independent circular byte regions in DDR, one per destination queue.
- Allocates write addresses with per-queue wrap and true occupancy/full checking, and stores completed-write descriptors in per-queue descriptor FIFOs.
- Drains one selected queue against a byte budget, and releases DDR space only when reads complete.
- Sits between the packet-to-DDR write engine and the DDR read scheduler/VLB.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32: DDR address width.
- P_BASE_ADDR, 32'h0000_0000: DDR address of queue 0 region.
- P_QUEUE_NUM, 4: number of queues (1..16); QW = max(1, clog2(P_QUEUE_NUM)).
- P_QUEUE_SPAN, 32'h0040_0000: bytes per queue region, power of two. Queue q base = P_BASE_ADDR + q*P_QUEUE_SPAN.
- P_DESC_DEPTH, 64: descriptor FIFO depth per queue, power of two.
- P_INFLIGHT, 8: maximum accepted reads awaiting i_rd_ddr_cpl.
- P_BEAT_SHIFT, 3: byte size of a length unit = 1<<P_BEAT_SHIFT.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset. One clock; i_rst is asynchronous, active-high.
- i_alloc_valid  in  1  write allocation request
- i_alloc_qid  in  QW  target queue
- i_alloc_len  in  16  length in beats
- o_alloc_ready  out  1  allocation accepted this cycle
- o_alloc_addr  out  C_M_AXI_ADDR_WIDTH  absolute DDR address, valid with the grant
- i_wr_cpl_valid  in  1  write completed
- o_wr_cpl_ready  out  1  descriptor push accepted
- i_wr_cpl_qid  in  QW  queue of the completion
- i_wr_cpl_addr  in  C_M_AXI_ADDR_WIDTH  address granted earlier
- i_wr_cpl_len  in  16  beats
- i_wr_cpl_strb  in  8  last-beat strobe
- i_drain_valid  in  1  drain request
- o_drain_ready  out  1  drain request accepted
- i_drain_qid  in  QW  queue to drain
- i_drain_budget  in  32  byte budget
- o_rd_valid  out  1  read descriptor valid
- i_rd_ready  in  1  read descriptor accepted
- o_rd_addr  out  C_M_AXI_ADDR_WIDTH  read address
- o_rd_len  out  16  read length in beats
- o_rd_strb  out  8  read last-beat strobe
- i_rd_ddr_cpl  in  1  one pulse per completed read, in acceptance order
- o_drain_done  out  1  one-cycle pulse at end of drain
- o_drain_bytes  out  32  bytes issued in the drain; held until next drain
- o_queue_size  out  32*P_QUEUE_NUM  committed bytes per queue, queue q at [32q+31:32q]
- o_queue_full  out  P_QUEUE_NUM  no room for a 2048-byte allocation

Behaviour:
- Reset: all outputs 0; all pointers, occupancy counters, FIFOs and in-flight FIFO cleared; drain FSM to IDLE. Reset mid-drain abandons the drain with no o_drain_done.
- Sizes: S = len<<P_BEAT_SHIFT. Per-queue state: wr_off, rd_off, used, all in bytes, range 0..P_QUEUE_SPAN.
- Allocation, registered, 1-cycle latency:
  - If wr_off+S > P_QUEUE_SPAN, then start = 0 and waste = P_QUEUE_SPAN-wr_off; otherwise start = wr_off and waste = 0.
  - Grant iff used+waste+S <= P_QUEUE_SPAN and S != 0.
  - On grant: o_alloc_ready=1 for one cycle, o_alloc_addr = base(q)+start, wr_off = start+S (wr_off == P_QUEUE_SPAN is stored as 0), used += waste+S.
  - If refused, the request is held and retried each cycle.
  - o_alloc_ready deasserts the cycle after the grant.
- Write completion:
  - o_wr_cpl_ready = descriptor FIFO of i_wr_cpl_qid not full.
  - Push {addr, len, strb}; o_queue_size[q] += S.
  - Per-queue completions arrive in allocation order.
  - Completion and read on the same queue in the same cycle: o_queue_size[q] updates net (+S_wr - S_rd).
- Drain FSM:
  - IDLE: o_drain_ready=1. On accept, latch qid and budget, sent=0, go to CHECK.
  - CHECK: if the FIFO is empty, or sent+S_head > budget, go to DONE. Else if in-flight is not full, pop the head into the output register and go to ISSUE.
  - ISSUE: o_rd_valid held until i_rd_ready. On accept: sent += S, o_queue_size[q] -= S, push {q, freed} to in-flight, go to CHECK.
  - DONE: o_drain_done=1 and o_drain_bytes=sent for one cycle, go to IDLE. A zero budget or empty queue yields done with 0 bytes.
- Freed bytes: with off = addr-base(q), freed = (off >= rd_off) ? off+S-rd_off : P_QUEUE_SPAN-rd_off+off+S. After computing, rd_off = off+S. This covers wrap waste.
- Release on i_rd_ddr_cpl: pop in-flight and subtract freed from that queue's used. If a release and an allocation hit the same queue in the same cycle, used updates net. i_rd_ddr_cpl with in-flight empty is ignored.
- o_queue_full[q] = used[q] > P_QUEUE_SPAN-2048, registered.

Test Plan:
- Single queue: alloc len 190 (1520 B) on q2, then write completion, then drain with budget 4000 -> o_alloc_addr = base+2*0x40_0000. One read is issued with addr base+0x800000, len 190. o_drain_bytes = 1520; o_queue_size[2] goes 1520 -> 0.
- Budget cut: three 1000 B packets in q0, drain budget 2500 -> exactly 2 reads, o_drain_bytes = 2000, o_queue_size[0] = 1000 after the drain.
- Wrap, P_QUEUE_SPAN=4096: allocs of 1600, 1600, then read/complete both, then alloc 1600 -> third o_alloc_addr = base+0. Freed includes 896 B waste, and used returns to 0 after all reads complete.
- Full: fill q1 to used = 4000 of 4096, request 200 B -> o_alloc_ready stays 0. After one i_rd_ddr_cpl frees 1000 B, the grant occurs the following cycle.
- Backpressure: hold i_rd_ready=0 for 10 cycles -> o_rd_valid and o_rd_addr stay stable. With P_INFLIGHT reads outstanding and no i_rd_ddr_cpl, no further o_rd_valid.
- Reset asserted mid-ISSUE -> all outputs 0 immediately, no o_drain_done; after release the first alloc returns base+0.
